// File: rtl/core_pkg.sv
// Shared fetch/decode types: opcode constants, field widths, fetch FSM
// states and the decoded-instruction record, plus the fixed-field decoder.
package core_pkg;

  localparam logic [5:0] OP_ALU = 6'd0;
  localparam logic [5:0] OP_LUI = 6'd15;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned FUNC_W   = 11;
  localparam int unsigned IMM_W    = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} fetch_state_t;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    reg_s;
    logic [REG_W-1:0]    reg_t;
    logic [REG_W-1:0]    reg_d;
    logic [FUNC_W-1:0]   func;
    logic [IMM_W-1:0]    imm;
  } dec_fields_t;

  // Fields not meaningful for the opcode (or an invalid head) read as zero.
  function automatic dec_fields_t decode(input logic valid, input logic [31:0] instr);
    dec_fields_t f;
    f = '0;
    if (valid) begin
      f.opcode = instr[31:26];
      if (f.opcode == OP_ALU) begin
        f.reg_s = instr[25:21];
        f.reg_t = instr[20:16];
        f.reg_d = instr[15:11];
        f.func  = instr[10:0];
      end else if (f.opcode == OP_LUI) begin
        f.reg_t = instr[20:16];
        f.imm   = instr[15:0];
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Instruction buffer: synchronous FIFO with push/pop/clear and occupancy
// count. DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buffer #(
  parameter int unsigned W     = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Pointer/occupancy update; clear wins over any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count is nonzero.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one icache read at a
// time, buffers returned words and presents the decoded head to execute.
// Optional FETCH_BYPASS_EN: a response arriving into an empty buffer is
// presented in the same cycle (and not stored if consumed immediately).
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned    PC_W     = 16,
  parameter int unsigned    ADDR_W   = 6,
  parameter int unsigned    INSTR_W  = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(10)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  output logic               icache_req,
  output logic [ADDR_W-1:0]  icache_read_addr,
  input  logic [INSTR_W-1:0] icache_read_data,
  input  logic               icache_data_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc,
  output logic [5:0]         dec_opcode,
  output logic [4:0]         dec_reg_s,
  output logic [4:0]         dec_reg_t,
  output logic [4:0]         dec_reg_d,
  output logic [10:0]        dec_func,
  output logic [15:0]        dec_imm
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned BUF_W = INSTR_W + PC_W;

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  req_pc_q, req_pc_d;
  logic             drop_q, drop_d;

  logic [CNT_W-1:0] buf_count;
  logic [BUF_W-1:0] buf_rdata;
  logic             buf_empty, buf_full, buf_push, buf_pop, buf_clear;
  logic             issue_fire, resp_fire, resp_keep;

  logic               head_valid;
  logic [INSTR_W-1:0] head_instr;
  logic [PC_W-1:0]    head_pc;
  dec_fields_t        dec_f;

  assign buf_empty  = (buf_count == '0);
  assign buf_full   = (buf_count == CNT_W'(DEPTH));
  assign issue_fire = clk_en && (state_q == ISSUE) && !buf_full && !redirect_valid;
  assign resp_fire  = clk_en && (state_q == WAIT) && icache_data_ready;
  assign resp_keep  = resp_fire && !drop_q && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = resp_keep && buf_empty;
  assign buf_push   = resp_keep && !(bypass_hit && dec_ready);
`else
  assign buf_push   = resp_keep;
`endif
  assign buf_pop   = clk_en && !redirect_valid && !buf_empty && dec_ready;
  assign buf_clear = clk_en && redirect_valid;

  // Fetch FSM next state; redirect is layered on top of the normal step.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    if (clk_en) begin
      unique case (state_q)
        IDLE:  state_d = ISSUE;
        ISSUE: if (issue_fire) begin
                 req_pc_d = pc_q;
                 pc_d     = pc_q + 1'b1;
                 state_d  = WAIT;
               end
        WAIT:  if (icache_data_ready) begin
                 drop_d  = 1'b0;
                 state_d = ISSUE;
               end
        default: state_d = IDLE;
      endcase
      // A response landing in the redirect cycle completes the request, so
      // only a still-outstanding one needs to be marked for dropping.
      if (redirect_valid) begin
        pc_d = redirect_pc;
        if (state_q == WAIT) begin
          if (!icache_data_ready) drop_d = 1'b1;
        end else begin
          state_d = ISSUE;
        end
      end
    end
  end

  // Fetch state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
    end
  end

  fetch_buffer #(
    .W     (BUF_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push),
    .pop   (buf_pop),
    .clear (buf_clear),
    .wdata ({icache_read_data, req_pc_q}),
    .rdata (buf_rdata),
    .count (buf_count)
  );

  // Select the presented head: buffer entry, or the live response on bypass.
  always_comb begin
    head_valid = !buf_empty;
    head_instr = buf_rdata[BUF_W-1:PC_W];
    head_pc    = buf_rdata[PC_W-1:0];
`ifdef FETCH_BYPASS_EN
    if (bypass_hit) begin
      head_valid = 1'b1;
      head_instr = icache_read_data;
      head_pc    = req_pc_q;
    end
`endif
    dec_f = decode(head_valid, head_instr);
  end

  assign icache_req       = issue_fire;
  assign icache_read_addr = issue_fire ? pc_q[ADDR_W-1:0] : '0;

  assign dec_valid  = head_valid;
  assign dec_instr  = head_valid ? head_instr : '0;
  assign dec_pc     = head_valid ? head_pc : '0;
  assign dec_opcode = dec_f.opcode;
  assign dec_reg_s  = dec_f.reg_s;
  assign dec_reg_t  = dec_f.reg_t;
  assign dec_reg_d  = dec_f.reg_d;
  assign dec_func   = dec_f.func;
  assign dec_imm    = dec_f.imm;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end: successor to the core's inline PC/fetch/decode logic.
- Owns the PC and issues word reads to the L1 icache with one request outstanding at a time.
- Buffers returned words in a DEPTH-entry FIFO and presents the head with decoded fields to the execute stage over a valid/ready handshake.
- Supports redirect (branch/jump) with flush of in-flight and buffered instructions.

Parameters:
- PC_W, 16: program counter width (word address).
- ADDR_W, 6: icache address width; icache_read_addr = pc[ADDR_W-1:0].
- INSTR_W, 32: instruction width (fixed-field decode assumes 32).
- DEPTH, 4: instruction buffer entries (power of two, ≥2).
- RESET_PC, 10: first fetch address after reset.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-low reset.
- clk_en, in, 1: global enable; when 0, all state holds.
- icache_req, out, 1: read request strobe, one cycle per request.
- icache_read_addr, out, ADDR_W: word address of the request.
- icache_read_data, in, INSTR_W: returned instruction.
- icache_data_ready, in, 1: read_data valid this cycle.
- redirect_valid, in, 1: flush and restart fetch.
- redirect_pc, in, PC_W: new fetch PC.
- dec_valid, out, 1: buffer head valid.
- dec_ready, in, 1: consumer accepts head.
- dec_instr, out, INSTR_W: head instruction.
- dec_pc, out, PC_W: PC of head instruction.
- dec_opcode, out, 6: instr[31:26].
- dec_reg_s, out, 5: instr[25:21] for OP_ALU, else 0.
- dec_reg_t, out, 5: instr[20:16] for OP_ALU/OP_LUI, else 0.
- dec_reg_d, out, 5: instr[15:11] for OP_ALU, else 0.
- dec_func, out, 11: instr[10:0] for OP_ALU, else 0.
- dec_imm, out, 16: instr[15:0] for OP_LUI, else 0.

Behaviour:
- Reset (async, rst=0):
  - pc=RESET_PC; FSM=IDLE; buffer empty; drop flag=0.
  - Outputs: icache_req=0, icache_read_addr=0, dec_valid=0; all dec_* fields=0 (never Z).
- FSM:
  - IDLE: go to ISSUE on the first enabled cycle.
  - ISSUE: if count<DEPTH, assert icache_req with addr=pc, record req_pc=pc, pc<=pc+1 (wraps mod 2^PC_W), go to WAIT. Otherwise stay in ISSUE with icache_req=0.
  - WAIT: on icache_data_ready, push {read_data, req_pc} unless drop=1, clear drop, go to ISSUE. Response latency ≥1 cycle; the unit waits indefinitely.
- Handshake:
  - A pop occurs when dec_valid&&dec_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Issue is gated on count<DEPTH at issue time. Because only one request is in flight, a response always has a free slot; overflow is impossible.
- Redirect (redirect_valid=1, clk_en=1):
  - Buffer cleared, pc<=redirect_pc.
  - In WAIT: drop<=1. The pending response is discarded and the FSM still waits for it.
  - In ISSUE/IDLE: go to ISSUE. No request is issued in the redirect cycle.
  - Overrides a same-cycle pop and push; a same-cycle response is discarded.
  - First fetched word after redirect has dec_pc=redirect_pc.
- Decode is a combinational slice of the buffer head. Fields are zeroed when dec_valid=0 or the opcode is not OP_ALU/OP_LUI.
- Default latency: response cycle N → dec_valid at N+1 (buffer registered).
- clk_en=0: no state change. icache_req is forced to 0 and responses are not sampled; the icache shares the enable.
- Reset mid-request: returns to the reset state. The icache is reset by the same rst, so no stale response arrives.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - When the buffer is empty and a non-dropped response arrives, dec_valid and the dec_* fields reflect icache_read_data combinationally that cycle (0-cycle latency).
  - If dec_ready=1 in that cycle, the word is consumed and not pushed; otherwise it is pushed.
- Undefined: always push, giving 1-cycle latency; dec_* outputs depend only on registered state.

Decomposition:
- core_pkg:
  - Opcode constants OP_ALU=6'd0, OP_LUI=6'd15.
  - Field width localparams.
  - fetch_state_t enum {IDLE, ISSUE, WAIT}.
  - Decoded-instruction struct dec_fields_t.
- Sub-module fetch_buffer: synchronous FIFO of {INSTR_W+PC_W} bits, DEPTH entries, push/pop/clear, count, wrap-around pointers.
- Decode stays inline.

Test Plan:
- Reset release, icache latency 1, dec_ready=1 → requests at addr 10,11,12… one every 2 cycles; dec_pc sequence 10,11,12; first dec_valid 1 cycle after the first response (bypass off).
- dec_ready=0 for 20 cycles, DEPTH=4 → exactly 4 requests issued, then icache_req stays 0, count=4. Raising dec_ready resumes issue the next cycle with no lost or duplicated PCs.
- Redirect to 0x0040 while in WAIT; the response for PC 13 arrives later → that word is never presented; the next dec_pc is 0x0040; buffer empty on the cycle after redirect.
- Redirect in the same cycle as a response and a pop → the response is dropped, the buffer is cleared, and the next request uses addr 0x0040[ADDR_W-1:0].
- Instruction 0x3C05_1234 (opcode 15) → dec_reg_t=5, dec_imm=0x1234, others 0. Instruction 0x0022_1820 (opcode 0) → reg_s=1, reg_t=2, reg_d=3, func=0x020, imm=0.
- pc=0xFFFF with PC_W=16 → next request at pc 0x0000 (addr 0). With FETCH_BYPASS_EN, empty buffer and dec_ready=1 → dec_valid in the same cycle as icache_data_ready and count stays 0.
